generador_rebote: RTL and testbench

- Synthesizable bounce emulator: turns a clean commanded button level into a bouncing button waveform with pseudorandom glitch widths.
- Drives the `boton` input of the debouncer (`rebote`) on-chip, so debouncing can be exercised in hardware and in simulation without hand-written toggle sequences.
- Single clock domain. Its output feeds `rebote.boton` directly.

---
 rtl/generador_rebote.sv | 138 +++++++++++++
 tb/tb_generador_rebote.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/generador_rebote.sv
// generador_rebote: turns a clean commanded level into a bouncing
// button waveform whose segment widths come from a 16-bit Galois LFSR.
// Ports: clk, rst (async, active high), boton_limpio (commanded level)
//        -> boton_rebote (bouncing level), ocupado (transition in
//        progress), eventos[7:0] (completed transitions, wraps).
module generador_rebote #(
  parameter int unsigned N_REBOTES = 3,
  parameter int unsigned ANCHO_MAX = 4,
  parameter int unsigned T_ASENTAR = 64,
  parameter logic [15:0] SEMILLA   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       boton_limpio,
  output logic       boton_rebote,
  output logic       ocupado,
  output logic [7:0] eventos
);

  localparam logic [1:0] ESTABLE  = 2'd0;
  localparam logic [1:0] REBOTE   = 2'd1;
  localparam logic [1:0] ASENTADO = 2'd2;

  localparam int unsigned SEG_MAX = 1 << ANCHO_MAX;
  localparam int unsigned T_MAX =
    (T_ASENTAR > SEG_MAX) ? T_ASENTAR : SEG_MAX;
  localparam int unsigned TW = $clog2(T_MAX + 1);

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED =
    (SEMILLA == 16'h0000) ? 16'h0001 : SEMILLA;
  localparam logic [TW-1:0] T_SET    = TW'(T_ASENTAR);
  localparam logic [TW-1:0] T_UNO    = TW'(1);
  localparam logic [4:0]    CONT_FIN = 5'(2 * N_REBOTES);

  logic [1:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    cont_q, cont_d;
  logic          boton_q, boton_d;
  logic          ocupado_q, ocupado_d;
  logic [7:0]    eventos_q, eventos_d;
  logic          nivel_act_q, nivel_act_d;
  logic          nivel_obj_q, nivel_obj_d;
  logic [TW-1:0] w;

  // Segment width 1..2^ANCHO_MAX from the pre-advance LFSR value.
  always_comb begin
    w = TW'(lfsr_q[ANCHO_MAX-1:0]) + T_UNO;
  end

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400)
                       : (lfsr_q >> 1);
    state_d     = state_q;
    timer_d     = timer_q;
    cont_d      = cont_q;
    boton_d     = boton_q;
    ocupado_d   = ocupado_q;
    eventos_d   = eventos_q;
    nivel_act_d = nivel_act_q;
    nivel_obj_d = nivel_obj_q;
    unique case (state_q)
      ESTABLE: begin
        if (boton_limpio != nivel_act_q) begin
          nivel_obj_d = boton_limpio;
          boton_d     = boton_limpio;
          cont_d      = 5'd0;
          ocupado_d   = 1'b1;
          if (N_REBOTES == 0) begin
            state_d = ASENTADO;
            timer_d = T_SET;
          end else begin
            state_d = REBOTE;
            timer_d = w;
          end
        end
      end
      REBOTE: begin
        if (timer_q == T_UNO) begin
          boton_d = ~boton_q;
          cont_d  = cont_q + 5'd1;
          // An even number of glitch toggles lands back on nivel_obj.
          if (cont_q + 5'd1 == CONT_FIN) begin
            state_d = ASENTADO;
            timer_d = T_SET;
          end else begin
            timer_d = w;
          end
        end else begin
          timer_d = timer_q - T_UNO;
        end
      end
      ASENTADO: begin
        if (timer_q == T_UNO) begin
          nivel_act_d = nivel_obj_q;
          eventos_d   = eventos_q + 8'd1;
          ocupado_d   = 1'b0;
          state_d     = ESTABLE;
        end else begin
          timer_d = timer_q - T_UNO;
        end
      end
      default: begin
        state_d = ESTABLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ESTABLE;
      lfsr_q      <= SEED;
      timer_q     <= '0;
      cont_q      <= 5'd0;
      boton_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      eventos_q   <= 8'd0;
      nivel_act_q <= 1'b0;
      nivel_obj_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      timer_q     <= timer_d;
      cont_q      <= cont_d;
      boton_q     <= boton_d;
      ocupado_q   <= ocupado_d;
      eventos_q   <= eventos_d;
      nivel_act_q <= nivel_act_d;
      nivel_obj_q <= nivel_obj_d;
    end
  end

  assign boton_rebote = boton_q;
  assign ocupado      = ocupado_q;
  assign eventos      = eventos_q;

endmodule

// File: tb/tb_generador_rebote.sv
// tb_generador_rebote: checks two generador_rebote instances (default
// bounce, and single-edge N_REBOTES=0/T_ASENTAR=4) against a schedule model.
module tb_generador_rebote;

  logic clk = 1'b0;
  logic rst;
  logic bl = 1'b1;

  logic       boton_a, ocup_a;
  logic [7:0] ev_a;
  logic       boton_b, ocup_b;
  logic [7:0] ev_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  generador_rebote #(
    .N_REBOTES(3), .ANCHO_MAX(4), .T_ASENTAR(64), .SEMILLA(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst), .boton_limpio(bl),
    .boton_rebote(boton_a), .ocupado(ocup_a), .eventos(ev_a)
  );

  generador_rebote #(
    .N_REBOTES(0), .ANCHO_MAX(4), .T_ASENTAR(4), .SEMILLA(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst), .boton_limpio(bl),
    .boton_rebote(boton_b), .ocupado(ocup_b), .eventos(ev_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // LFSR value seen before edge k after reset release.
  localparam int LN = 16384;
  logic [15:0] lseq [LN];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  initial begin
    lseq[0] = 16'hACE1;
    for (int k = 1; k < LN; k++) lseq[k] = lfsr_next(lseq[k-1]);
  end

  // Model: on a trigger the whole transition is scheduled up front as a
  // list of toggle edges plus the settle-end edge.
  int nr [2] = '{3, 0};
  int ta [2] = '{64, 4};
  int n_edge = 0;
  bit m_busy [2] = '{0, 0};
  bit m_lvl  [2] = '{0, 0};
  bit m_tgt  [2] = '{0, 0};
  bit m_out  [2] = '{0, 0};
  int m_end  [2] = '{0, 0};
  int m_ev   [2] = '{0, 0};
  int sc     [2] = '{0, 0};
  int sp     [2] = '{0, 0};
  int sched  [2][32];

  task automatic model_reset();
    n_edge = 0;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_lvl[i] = 0; m_tgt[i] = 0; m_out[i] = 0;
      m_end[i] = 0; m_ev[i] = 0; sc[i] = 0; sp[i] = 0;
    end
  endtask

  task automatic step_one(input int i);
    int t;
    if (m_busy[i]) begin
      if (sp[i] < sc[i] && sched[i][sp[i]] == n_edge) begin
        m_out[i] = ~m_out[i];
        sp[i]++;
      end
      if (n_edge == m_end[i]) begin
        m_busy[i] = 0;
        m_lvl[i]  = m_tgt[i];
        m_ev[i]   = (m_ev[i] + 1) % 256;
      end
    end else if (bl != m_lvl[i]) begin
      m_busy[i] = 1;
      m_tgt[i]  = bl;
      m_out[i]  = bl;
      sc[i] = 0;
      sp[i] = 0;
      t = n_edge;
      for (int k = 0; k < 2 * nr[i]; k++) begin
        t = t + int'(lseq[t % LN][3:0]) + 1;
        sched[i][sc[i]] = t;
        sc[i]++;
      end
      m_end[i] = t + ta[i];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      step_one(0);
      step_one(1);
      n_edge++;
    end
  end

  always @(negedge clk) begin
    check("a_boton",   int'(boton_a), int'(m_out[0]));
    check("a_ocupado", int'(ocup_a),  int'(m_busy[0]));
    check("a_eventos", int'(ev_a),    m_ev[0]);
    check("b_boton",   int'(boton_b), int'(m_out[1]));
    check("b_ocupado", int'(ocup_b),  int'(m_busy[1]));
    check("b_eventos", int'(ev_b),    m_ev[1]);
  end

  int edges_a = 0;
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    if (boton_a !== prev_a) edges_a++;
    prev_a = boton_a;
  end

  task automatic set_bl(input logic v);
    @(posedge clk);
    #2 bl = v;
  endtask

  task automatic wait_idle(input bit only_a);
    bit done;
    done = 0;
    @(posedge clk);
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      #1;
      if (!ocup_a && (only_a || !ocup_b)) done = 1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: ocupado still %0d/%0d", ocup_a, ocup_b);
    end
  endtask

  // Hand-derived: seed ACE1 -> w=2, lfsr at edge 2 is 7138 -> w=9.
  task automatic press_checks();
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      case (e)
        0: begin
          check("p_a_boton0", int'(boton_a), 1);
          check("p_a_ocup0",  int'(ocup_a),  1);
          check("p_b_boton0", int'(boton_b), 1);
          check("p_b_ocup0",  int'(ocup_b),  1);
        end
        1:  check("p_a_boton1",  int'(boton_a), 1);
        2:  check("p_a_boton2",  int'(boton_a), 0);
        3:  check("p_b_ocup3",   int'(ocup_b),  1);
        4: begin
          check("p_b_ocup4", int'(ocup_b), 0);
          check("p_b_ev4",   int'(ev_b),   1);
        end
        10: check("p_a_boton10", int'(boton_a), 0);
        11: check("p_a_boton11", int'(boton_a), 1);
        default: ;
      endcase
    end
  endtask

  int base;
  int snap;
  bit hit;

  initial begin
    rst = 1'b1;
    bl  = 1'b1;
    check("lfsr1", int'(lseq[1]), 32'hE270);
    check("lfsr2", int'(lseq[2]), 32'h7138);

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_boton", int'(boton_a), 0);
    check("rst_a_ocup",  int'(ocup_a),  0);
    check("rst_a_ev",    int'(ev_a),    0);
    check("rst_b_boton", int'(boton_b), 0);
    #1 rst = 1'b0;
    base = edges_a;
    press_checks();
    wait_idle(0);
    check("press_edges", edges_a - base, 7);
    check("press_ev",    int'(ev_a),     1);
    check("press_lvl",   int'(boton_a),  1);

    base = edges_a;
    set_bl(1'b0);
    wait_idle(0);
    check("rel_edges", edges_a - base, 7);
    check("rel_ev",    int'(ev_a),     2);
    check("rel_lvl",   int'(boton_a),  0);

    set_bl(1'b1);
    repeat (3) @(posedge clk);
    #2 bl = 1'b0;
    repeat (2) @(posedge clk);
    #2 bl = 1'b1;
    wait_idle(0);
    check("pulse_ev", int'(ev_a), 3);
    repeat (10) @(negedge clk);
    #1;
    check("pulse_idle", int'(ocup_a), 0);
    check("pulse_ev2",  int'(ev_a),   3);

    set_bl(1'b0);
    repeat (10) @(posedge clk);
    #2 bl = 1'b1;
    wait_idle(1);
    @(posedge clk);
    #1;
    check("retrig_ocup",  int'(ocup_a),  1);
    check("retrig_boton", int'(boton_a), 1);
    check("retrig_ev",    int'(ev_a),    4);
    wait_idle(0);
    check("retrig_ev2", int'(ev_a), 5);

    snap = m_ev[1];
    for (int k = 0; k < 256; k++) begin
      set_bl(~bl);
      repeat (5) @(posedge clk);
    end
    wait_idle(0);
    wait_idle(0);
    check("wrap_b_ev", int'(ev_b), snap);

    set_bl(1'b0);
    wait_idle(0);
    set_bl(1'b1);
    base = edges_a;
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (edges_a - base >= 3) hit = 1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL third_edge: edges %0d", edges_a - base);
    end
    check("pre_rst_boton", int'(boton_a), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_a_boton", int'(boton_a), 0);
    check("mid_rst_a_ocup",  int'(ocup_a),  0);
    check("mid_rst_a_ev",    int'(ev_a),    0);
    check("mid_rst_b_ocup",  int'(ocup_b),  0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    base = edges_a;
    press_checks();
    wait_idle(0);
    check("replay_edges", edges_a - base, 7);
    check("replay_ev",    int'(ev_a),     1);
    base = edges_a;
    set_bl(1'b0);
    wait_idle(0);
    check("replay_rel_edges", edges_a - base, 7);
    check("replay_rel_ev",    int'(ev_a),     2);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
